frame_loader: RTL and testbench
===============================

// Module: frame_loader
// PURPOSE
//  Upstream feeder for the LED panel scan driver. Receives a packed byte stream (host link),
//  unpacks 12-bit greyscale words and writes them into a double-buffered frame RAM that the
//  scan driver reads in place of a fixed image ROM. Bank swap is locked to the driver's frame
//  boundary, so the panel never shows a torn frame.
// PARAMETERS
//  FRAME_WORDS  4608         12-bit words per frame (8 rows x 576); must be even
//  SYNC_BYTE    8'hA5        frame start marker
//  TIMEOUT      1_000_000    idle clocks allowed between bytes inside a frame
// PORTS
//  clock        in   1   single system clock; all logic on posedge
//  reset        in   1   asynchronous, active-high reset
//  in_data      in   8   stream byte
//  in_valid     in   1   in_data valid
//  in_ready     out  1   byte accepted when in_valid && in_ready
//  frame_sync   in   1   1-cycle pulse from scan driver when its row offset wraps to 0
//  wr_en        out  1   frame RAM write strobe
//  wr_addr      out  14  {bank, word index[12:0]}
//  wr_data      out  12  word to write
//  disp_bank    out  1   bank the scan driver must read (driver address = {disp_bank, idx})
//  frame_err    out  1   1-cycle pulse: frame aborted by timeout
// BEHAVIOUR
//  - Reset (async): state HUNT, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, disp_bank=0,
//    frame_err=0, word index=0, timeout counter=0. Write bank is always ~disp_bank.
//  - States: HUNT, B0, B1, B2, WAIT_SWAP. in_ready=1 in all states except WAIT_SWAP.
//  - HUNT: bytes != SYNC_BYTE are dropped silently; SYNC_BYTE -> B0, index=0.
//  - Packing: 3 bytes -> 2 words. w0={b0,b1[7:4]}, w1={b1[3:0],b2}. B0 stores b0 -> B1.
//    B1 accept: w0 written -> B2. B2 accept: w1 written -> B0, or WAIT_SWAP if w1 was word
//    FRAME_WORDS-1. No sync byte inside payload: 0xA5 in B0/B1/B2 is ordinary data.
//  - Writes are registered: wr_en high exactly 1 cycle, the cycle after the accepting
//    handshake; wr_addr={~disp_bank, index}; index increments after each write, 13-bit, never
//    exceeds FRAME_WORDS-1 (no wrap inside a frame).
//  - WAIT_SWAP: in_ready=0. Next frame_sync pulse toggles disp_bank -> HUNT (in_ready=1 the
//    following cycle). A frame_sync in the same cycle as the last-word handshake is ignored;
//    swap waits for the next pulse. frame_sync in any other state: no effect.
//  - Timeout: counter clears on every accepted byte and in HUNT/WAIT_SWAP; in B0/B1/B2 it
//    counts clocks; reaching TIMEOUT -> frame_err pulse, -> HUNT, no swap, partial data left
//    in write bank (overwritten by next frame).
//  - Reset mid-frame: all state lost immediately; display returns to bank 0.
// STRUCTURE
//  - Package led_frame_pkg: FRAME_WORDS, ROW_WORDS=576, SYNC_BYTE, IDX_W=13, state enum,
//    shared with the scan driver.
//  - Sub-module frame_bank_ram: simple dual-port 2xFRAME_WORDS x 12, write port from this
//    block, read port {disp_bank, idx} to the scan driver; instantiated by the top level.
// TESTING
//  1 reset; send A5,12,34,56 -> writes (0x2000,0x123) then (0x2001,0x456), 1 cycle after each
//    of bytes 2 and 3; disp_bank=0.
//  2 send 00,FF,5A then A5,AB,CD,EF -> no writes for first three bytes; writes 0xABC, 0xDEF
//    at idx 0,1.
//  3 full frame (A5 + 6912 bytes) -> last write idx 4607; in_ready=0 next cycle; disp_bank
//    stays 0 until frame_sync; then disp_bank=1, in_ready=1, next frame writes bank 0 (0x0000..).
//  4 frame_sync coincident with final byte handshake -> no swap; swap on next frame_sync.
//  5 TIMEOUT=16: A5 + 100 bytes then idle -> frame_err one pulse after 16 idle clocks, HUNT,
//    disp_bank unchanged; following A5 restarts at idx 0.
//  6 assert reset mid-frame (idx 300, disp_bank=1) -> same-cycle return to all reset values.

Source files
------------

// File: rtl/led_frame_pkg.sv
// Shared definitions for the LED panel frame path (frame_loader and the scan driver).
//   FRAME_WORDS / ROW_WORDS : frame geometry in 12-bit words (8 rows x 576)
//   SYNC_BYTE               : host-link frame start marker
//   IDX_W / WORD_W          : word index and greyscale word widths
//   frame_state_t           : loader FSM states
//   wr_req_t                : frame RAM write request {en, {bank, idx}, data}
package led_frame_pkg;

   localparam int         FRAME_WORDS = 4608;
   localparam int         ROW_WORDS   = 576;
   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         IDX_W       = 13;
   localparam int         WORD_W      = 12;

   typedef enum logic [2:0] {
      HUNT,
      B0,
      B1,
      B2,
      WAIT_SWAP
   } frame_state_t;

   typedef struct packed {
      logic              en;
      logic [IDX_W:0]    addr;
      logic [WORD_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Double-buffered frame RAM, 2 x FRAME_WORDS x 12, simple dual port.
//   clock   : write and read clock
//   wr      : write request {en, {bank, idx}, data} from the loader
//   rd_addr : {bank, idx} from the scan driver
//   rd_data : registered read data, one cycle after rd_addr
// The {bank, idx} address map has a hole above FRAME_WORDS-1 in each bank, so it is
// folded to a dense linear index before touching the array.
module frame_bank_ram
   import led_frame_pkg::*;
#(
   parameter int FRAME_WORDS = 4608
) (
   input  logic              clock,
   input  wr_req_t           wr,
   input  logic [IDX_W:0]    rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   localparam int DEPTH = 2 * FRAME_WORDS;
   localparam int AW    = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];

   function automatic logic [AW-1:0] lin(input logic [IDX_W:0] a);
      return a[IDX_W] ? AW'(FRAME_WORDS) + AW'(a[IDX_W-1:0]) : AW'(a[IDX_W-1:0]);
   endfunction

   always_ff @(posedge clock) begin
      if (wr.en) mem[lin(wr.addr)] <= wr.data;
      rd_data <= mem[lin(rd_addr)];
   end

endmodule

// File: rtl/frame_loader.sv
// Host-link frame loader: hunts for SYNC_BYTE, unpacks 3 bytes -> 2 12-bit words and
// writes them into the back bank of frame_bank_ram. A completed frame is handed to the
// scan driver only on its frame_sync pulse, so the panel never shows a torn frame.
//   clock, reset        : system clock, async active-high reset
//   in_data/valid/ready : byte stream, accepted on valid && ready
//   frame_sync          : scan driver frame boundary pulse
//   wr_en/addr/data     : registered frame RAM write port (also exported)
//   disp_bank           : bank the scan driver reads
//   frame_err           : 1-cycle pulse when a frame is aborted by timeout
//   rd_idx / rd_data    : scan driver read port, address {disp_bank, rd_idx}
module frame_loader #(
   parameter int         FRAME_WORDS = 4608,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT     = 1_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        frame_sync,
   output logic        wr_en,
   output logic [13:0] wr_addr,
   output logic [11:0] wr_data,
   output logic        disp_bank,
   output logic        frame_err,
   input  logic [12:0] rd_idx,
   output logic [11:0] rd_data
);
   import led_frame_pkg::*;

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

   frame_state_t      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        byte0_q, byte0_d;
   logic [3:0]        nib_q, nib_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   wr_req_t           wr_q, wr_d;
   logic              disp_q, disp_d;
   logic              err_q, err_d;
   logic              accept;

   assign in_ready = (state_q != WAIT_SWAP);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
         idx_q   <= '0;
         byte0_q <= '0;
         nib_q   <= '0;
         tmo_q   <= '0;
         wr_q    <= '0;
         disp_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         byte0_q <= byte0_d;
         nib_q   <= nib_d;
         tmo_q   <= tmo_d;
         wr_q    <= wr_d;
         disp_q  <= disp_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      byte0_d   = byte0_q;
      nib_d     = nib_q;
      tmo_d     = '0;
      wr_d      = wr_q;      // addr/data hold their last value between strobes
      wr_d.en   = 1'b0;
      disp_d    = disp_q;
      err_d     = 1'b0;
      case (state_q)
         HUNT: begin
            if (accept && in_data == SYNC_BYTE) begin
               state_d = B0;
               idx_d   = '0;
            end
         end
         B0, B1, B2: begin
            if (accept) begin
               case (state_q)
                  B0: begin
                     byte0_d = in_data;
                     state_d = B1;
                  end
                  B1: begin
                     // FRAME_WORDS is even, so w0 is never the last word
                     wr_d.en   = 1'b1;
                     wr_d.addr = {~disp_q, idx_q};
                     wr_d.data = {byte0_q, in_data[7:4]};
                     nib_d     = in_data[3:0];
                     idx_d     = idx_q + 1'b1;
                     state_d   = B2;
                  end
                  default: begin
                     wr_d.en   = 1'b1;
                     wr_d.addr = {~disp_q, idx_q};
                     wr_d.data = {nib_q, in_data};
                     if (idx_q == LAST_IDX) begin
                        state_d = WAIT_SWAP;
                     end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = B0;
                     end
                  end
               endcase
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               // TIMEOUT-th idle clock: abandon the frame, back bank keeps partial data
               err_d   = 1'b1;
               state_d = HUNT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         WAIT_SWAP: begin
            if (frame_sync) begin
               disp_d  = ~disp_q;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   assign wr_en     = wr_q.en;
   assign wr_addr   = wr_q.addr;
   assign wr_data   = wr_q.data;
   assign disp_bank = disp_q;
   assign frame_err = err_q;

   frame_bank_ram #(
      .FRAME_WORDS (FRAME_WORDS)
   ) u_ram (
      .clock   (clock),
      .wr      (wr_q),
      .rd_addr ({disp_q, rd_idx}),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;

   localparam int FW  = 4608;
   localparam int TMO = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        frame_sync = 1'b0;
   logic        wr_en;
   logic [13:0] wr_addr;
   logic [11:0] wr_data;
   logic        disp_bank;
   logic        frame_err;
   logic [12:0] rd_idx = '0;
   logic [11:0] rd_data;

   int n_chk = 0;
   int n_err = 0;

   frame_loader #(.FRAME_WORDS(FW), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .frame_sync(frame_sync), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .disp_bank(disp_bank), .frame_err(frame_err),
      .rd_idx(rd_idx), .rd_data(rd_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // one byte per call, handshake on the next posedge; returns 1ns after that edge
   task automatic send(input logic [7:0] b, input logic fs);
      in_data    = b;
      in_valid   = 1'b1;
      frame_sync = fs;
      @(posedge clock);
      #1;
      in_valid   = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic [13:0] a, input logic [11:0] d);
      chk(tag, 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, a, d}));
   endtask

   function automatic logic [11:0] pat(input int k);
      return 12'(k * 7 + 3);
   endfunction

   // full frame with pattern words into bank wb; optional frame_sync on the final byte
   task automatic send_frame(input logic wb, input logic sync_last);
      logic [11:0] wa, wz;
      send(8'hA5, 1'b0);
      for (int p = 0; p < FW / 2; p++) begin
         wa = pat(2 * p);
         wz = pat(2 * p + 1);
         send(wa[11:4], 1'b0);
         send({wa[3:0], wz[11:8]}, 1'b0);
         chk_wr("frm_w0", {wb, 13'(2 * p)}, wa);
         send(wz[7:0], sync_last && (p == FW / 2 - 1));
         chk_wr("frm_w1", {wb, 13'(2 * p + 1)}, wz);
      end
   endtask

   initial begin
      int quiet;
      #2;
      // ---- 1: reset values and basic unpacking
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
      chk("rst_disp", 32'(disp_bank), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      do_reset();
      send(8'hA5, 1'b0);  chk("t1_sync_nowr", 32'(wr_en), 32'd0);
      send(8'h12, 1'b0);  chk("t1_b0_nowr", 32'(wr_en), 32'd0);
      send(8'h34, 1'b0);  chk_wr("t1_w0", 14'h2000, 12'h123);
      send(8'h56, 1'b0);  chk_wr("t1_w1", 14'h2001, 12'h456);
      tick();             chk("t1_wr_1cyc", 32'(wr_en), 32'd0);
      chk("t1_disp", 32'(disp_bank), 32'd0);

      // ---- 2: junk before sync is dropped, A5 only marks the start
      do_reset();
      send(8'h00, 1'b0);  chk("t2_j0", 32'({wr_en, in_ready}), 32'b01);
      send(8'hFF, 1'b0);  chk("t2_j1", 32'({wr_en, in_ready}), 32'b01);
      send(8'h5A, 1'b0);  chk("t2_j2", 32'({wr_en, in_ready}), 32'b01);
      send(8'hA5, 1'b0);  chk("t2_sync", 32'(wr_en), 32'd0);
      send(8'hAB, 1'b0);
      send(8'hCD, 1'b0);  chk_wr("t2_w0", 14'h2000, 12'hABC);
      send(8'hEF, 1'b0);  chk_wr("t2_w1", 14'h2001, 12'hDEF);

      // ---- 3: full frame, swap on frame_sync, next frame goes to bank 0
      do_reset();
      send_frame(1'b1, 1'b0);
      chk("t3_last_addr", 32'(wr_addr), 32'h31FF);
      chk("t3_wait_ready", 32'(in_ready), 32'd0);
      send(8'h77, 1'b0);  // offered while not ready: must be ignored
      for (int i = 0; i < 4; i++) tick();
      chk("t3_wait_hold", 32'({in_ready, disp_bank, wr_en}), 32'b000);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk("t3_swap", 32'({in_ready, disp_bank}), 32'b11);
      rd_idx = 13'd0;    tick(); chk("t3_rd0", 32'(rd_data), 32'(pat(0)));
      rd_idx = 13'd4607; tick(); chk("t3_rdlast", 32'(rd_data), 32'(pat(4607)));
      send(8'hA5, 1'b0);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);  chk_wr("t3_nxt_w0", 14'h0000, 12'h112);
      send(8'h33, 1'b0);  chk_wr("t3_nxt_w1", 14'h0001, 12'h233);

      // ---- 6: async reset mid-frame (idx 300, disp_bank 1)
      for (int i = 0; i < 447; i++) send(8'h3C, 1'b0);
      chk_wr("t6_pre", 14'h012B, 12'hC3C);
      chk("t6_pre_disp", 32'(disp_bank), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6_async", 32'({in_ready, wr_en, wr_addr, wr_data, disp_bank, frame_err}),
          32'({1'b1, 1'b0, 14'h0, 12'h0, 1'b0, 1'b0}));
      tick();
      reset = 1'b0;
      send(8'hA5, 1'b0);
      send(8'h9A, 1'b0);
      send(8'hBC, 1'b0);  chk_wr("t6_w0", 14'h2000, 12'h9AB);
      send(8'hDE, 1'b0);  chk_wr("t6_w1", 14'h2001, 12'hCDE);

      // ---- 4: frame_sync coincident with last handshake is ignored
      do_reset();
      send_frame(1'b1, 1'b1);
      chk("t4_nosw", 32'({in_ready, disp_bank}), 32'b00);
      for (int i = 0; i < 3; i++) tick();
      chk("t4_hold", 32'({in_ready, disp_bank}), 32'b00);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk("t4_swap", 32'({in_ready, disp_bank}), 32'b11);

      // ---- 5: timeout after 16 idle clocks inside a frame
      do_reset();
      send(8'hA5, 1'b0);
      for (int i = 0; i < 100; i++) send(8'(i), 1'b0);
      quiet = 0;
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         if (frame_err) quiet++;
      end
      chk("t5_early_err", 32'(quiet), 32'd0);
      tick();
      chk("t5_err", 32'({frame_err, in_ready, disp_bank}), 32'b110);
      tick();
      chk("t5_err_1cyc", 32'(frame_err), 32'd0);
      send(8'h01, 1'b0);  chk("t5_hunt_drop", 32'(wr_en), 32'd0);
      send(8'hA5, 1'b0);
      send(8'h01, 1'b0);
      send(8'h23, 1'b0);  chk_wr("t5_w0", 14'h2000, 12'h012);
      send(8'h45, 1'b0);  chk_wr("t5_w1", 14'h2001, 12'h345);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
